// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Bits needed to count 0..w-1, never less than one.
  function automatic int cnt_width(input int w);
    int r;
    r = 0;
    while ((1 << r) < w) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two half-adder cells and an OR of their carries.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Combinational half-adder cell: s = a ^ b, c = a & b.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first WIDTH-bit adder with start/done handshake.
// Optional subtract mode (sub port, borrow on carry_out) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q;
  logic [WIDTH-1:0]   a_sh_q, b_sh_q, sh_q, sum_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               c_q, cout_q, busy_q, done_q;
  logic               s_bit, c_next;
  logic [WIDTH-1:0]   sh_d, b_load_d;
  logic               c_load_d, cout_d;

  full_adder_bit u_fa (
    .a   (a_sh_q[0]),
    .b   (b_sh_q[0]),
    .cin (c_q),
    .s   (s_bit),
    .cout(c_next)
  );

  assign sh_d = {s_bit, sh_q[WIDTH-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;
  // Two's-complement subtract: invert B and inject the +1 as the initial carry.
  assign b_load_d = sub ? ~op_b : op_b;
  assign c_load_d = sub;
  assign cout_d   = c_next ^ sub_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)                      sub_q <= 1'b0;
    else if (state_q == IDLE && start) sub_q <= sub;
  end
`else
  assign b_load_d = op_b;
  assign c_load_d = 1'b0;
  assign cout_d   = c_next;
`endif

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sh_q    <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= op_a;
            b_sh_q  <= b_load_d;
            c_q     <= c_load_d;
            cnt_q   <= '0;
            sh_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sh_q   <= sh_d;
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          c_q    <= c_next;
          // Ports update only here so partial sums never escape.
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            sum_q   <= sh_d;
            cout_q  <= cout_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: arithmetic reference model plus directed vectors.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, carry_out;
  logic [W-1:0] sum;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub_i = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .start    (start),
    .op_a     (a),
    .op_b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub      (sub_i),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1..W computing, W+1 result cycle.
  int           m_phase = 0;
  logic [W:0]   m_res;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0;
      m_sum   = '0;
      m_cout  = 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase = 1;
        m_res   = {1'b0, a} + {1'b0, b};
`ifdef SERIAL_ADDER_SUB_EN
        if (sub_i) m_res = {(a < b), a - b};
`endif
      end
    end else if (m_phase < W) begin
      m_phase++;
    end else if (m_phase == W) begin
      m_phase = W + 1;
      m_sum   = m_res[W-1:0];
      m_cout  = m_res[W];
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_busy", busy, (m_phase >= 1 && m_phase <= W));
      chk("model_done", done, (m_phase == W + 1));
      chk("model_sum", sum, m_sum);
      chk("model_cout", carry_out, m_cout);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start(input logic [W-1:0] xa, input logic [W-1:0] xb);
    a = xa; b = xb; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!done && c < 40) begin tick(); c++; end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done want done within 40 cycles");
    end
  endtask

  initial begin
    int nb, doneat, nd, last, cnt;
    logic [W-1:0] s_at;
    logic         c_at;

    tick();
    chk_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", carry_out, 0);

    // 3C + 5A: latency and busy width
    do_start(8'h3C, 8'h5A);
    nb = 0; doneat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) nb++;
      if (done && doneat == 0) doneat = i;
      tick();
    end
    chk("lat_done", doneat, 9);
    chk("lat_busy", nb, 8);
    chk("sum_3C5A", sum, 8'h96);
    chk("cout_3C5A", carry_out, 0);

    // FF + 01 wrap, then hold
    do_start(8'hFF, 8'h01);
    wait_done();
    chk("sum_FF01", sum, 8'h00);
    chk("cout_FF01", carry_out, 1);
    tick();
    for (int i = 0; i < 20; i++) begin
      chk("hold_sum", sum, 8'h00);
      chk("hold_cout", carry_out, 1);
      tick();
    end

    // Restart request during SHIFT is ignored
    do_start(8'h12, 8'h34);
    tick(); tick();
    a = 8'h11; b = 8'h22; start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0; s_at = '0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin nd++; s_at = sum; end
      tick();
    end
    chk("ign_ndone", nd, 1);
    chk("ign_sum", s_at, 8'h46);

    // Reset aborts an operation in SHIFT
    do_start(8'hAA, 8'h55);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_cout", carry_out, 0);
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) nd++;
      tick();
    end
    chk("abort_nodone", nd, 0);
    do_start(8'h01, 8'h02);
    wait_done();
    chk("sum_0102", sum, 8'h03);
    chk("cout_0102", carry_out, 0);
    tick();

    // Back-to-back with start held high
    a = 8'h80; b = 8'h80; start = 1'b1;
    last = -1; cnt = 0;
    for (int i = 0; i < 45; i++) begin
      if (done) begin
        if (last >= 0) chk("b2b_period", i - last, 10);
        chk("b2b_sum", sum, 8'h00);
        chk("b2b_cout", carry_out, 1);
        last = i; cnt++;
      end
      tick();
    end
    start = 1'b0;
    chk("b2b_count", (cnt >= 4), 1);
    repeat (12) tick();

`ifdef SERIAL_ADDER_SUB_EN
    sub_i = 1'b1;
    do_start(8'h05, 8'h07);
    wait_done();
    s_at = sum; c_at = carry_out;
    chk("sub_0507_sum", s_at, 8'hFE);
    chk("sub_0507_bor", c_at, 1);
    tick();
    do_start(8'h07, 8'h05);
    wait_done();
    chk("sub_0705_sum", sum, 8'h02);
    chk("sub_0705_bor", carry_out, 0);
    tick();
    sub_i = 1'b0;
    do_start(8'h07, 8'h05);
    wait_done();
    chk("add_0705_sum", sum, 8'h0C);
    tick();
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
